// File: rtl/vce2_agu_mc.sv
// Multi-channel strided address generation unit: loads one base/stride per operand
// channel, then streams byte addresses per channel. Optional wrap flags: VCE2_AGU_OVF_EN.
module vce2_agu_mc #(
  parameter  int AddrWidth   = 32,
  parameter  int NumOps      = 3,
  parameter  int StrideWidth = 12,
  parameter  int MaxVl       = 64,
  localparam int VlW         = $clog2(MaxVl + 1),
  localparam int OpW         = (NumOps > 1) ? $clog2(NumOps) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [VlW-1:0]         vl_i,
  input  logic                   abort_i,
  input  logic                   base_valid_i,
  output logic                   base_ready_o,
  input  logic [AddrWidth-3:0]   base_addr_i,
  input  logic [StrideWidth-1:0] stride_i,
  output logic [OpW-1:0]         rf_port_sel_o,
  input  logic [OpW-1:0]         op_sel_i,
  input  logic                   req_i,
  output logic [AddrWidth-1:0]   addr_o,
  output logic                   addr_valid_o,
  output logic                   last_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [NumOps-1:0]      ovf_o
);

  localparam int CntW = AddrWidth - 2;
  localparam logic [OpW:0] NumOpsW = (OpW + 1)'(NumOps);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q [NumOps];
  logic [StrideWidth-1:0] str_q [NumOps];
  logic [VlW-1:0]         rem_q [NumOps];
  logic [VlW-1:0]         vl_q, vl_sat;
  logic [OpW-1:0]         k_q, sel_idx;
  logic                   done_q, done_d;
  logic                   start_acc, load_hs, adv;
  logic                   sel_ok, in_run, all_empty;
  logic [CntW-1:0]        str_ext, cnt_nxt;

  assign vl_sat  = (vl_i > VlW'(MaxVl)) ? VlW'(MaxVl) : vl_i;
  assign in_run  = (state_q == StRun);
  assign sel_ok  = ({1'b0, op_sel_i} < NumOpsW);
  // Out-of-range selects are redirected to channel 0 and then masked off.
  assign sel_idx = sel_ok ? op_sel_i : '0;
  assign str_ext = CntW'($signed(str_q[sel_idx]));

  always_comb begin
    all_empty = 1'b1;
    for (int i = 0; i < NumOps; i++) begin
      if (rem_q[i] != '0) all_empty = 1'b0;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    start_acc = 1'b0;
    load_hs   = 1'b0;
    adv       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          start_acc = 1'b1;
          if (vl_sat != '0) state_d = StLoad;
          else              done_d  = 1'b1;
        end
      end
      StLoad: begin
        if (base_valid_i) begin
          load_hs = 1'b1;
          if (k_q == OpW'(NumOps - 1)) state_d = StRun;
        end
      end
      StRun: begin
        if (all_empty) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          adv = req_i & addr_valid_o;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over everything and leaves the channel registers untouched.
    if (abort_i) begin
      state_d   = StIdle;
      done_d    = 1'b0;
      start_acc = 1'b0;
      load_hs   = 1'b0;
      adv       = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
      vl_q    <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_acc) begin
        vl_q <= vl_sat;
        k_q  <= '0;
      end else if (load_hs) begin
        k_q <= k_q + 1'b1;
      end
    end
  end

  // NOTE: the per-channel arrays are small flop banks with defined reset values,
  // so they are reset like any other state rather than treated as a RAM.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumOps; i++) begin
        cnt_q[i] <= '0;
        str_q[i] <= '0;
        rem_q[i] <= '0;
      end
    end else if (load_hs) begin
      cnt_q[k_q] <= base_addr_i;
      str_q[k_q] <= stride_i;
      rem_q[k_q] <= vl_q;
    end else if (adv) begin
      cnt_q[sel_idx] <= cnt_nxt;
      rem_q[sel_idx] <= rem_q[sel_idx] - 1'b1;
    end
  end

`ifdef VCE2_AGU_OVF_EN
  logic [CntW:0]     sum;
  logic              wrap;
  logic [NumOps-1:0] ovf_q;

  assign sum     = {1'b0, cnt_q[sel_idx]} + {1'b0, str_ext};
  assign cnt_nxt = sum[CntW-1:0];
  // Adding a negative stride borrows exactly when the two's-complement add does not carry.
  assign wrap    = str_q[sel_idx][StrideWidth-1] ? ~sum[CntW] : sum[CntW];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)            ovf_q          <= '0;
    else if (start_acc)     ovf_q          <= '0;
    else if (adv && wrap)   ovf_q[sel_idx] <= 1'b1;
  end

  assign ovf_o = ovf_q;
`else
  assign cnt_nxt = cnt_q[sel_idx] + str_ext;
  assign ovf_o   = '0;
`endif

  assign base_ready_o  = (state_q == StLoad);
  assign rf_port_sel_o = (state_q == StLoad) ? k_q : '0;
  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign addr_valid_o  = in_run && sel_ok && (rem_q[sel_idx] != '0);
  assign last_o        = in_run && sel_ok && (rem_q[sel_idx] == VlW'(1));
  assign addr_o        = (in_run && sel_ok) ? {cnt_q[sel_idx], 2'b00} : '0;

endmodule

// File: tb/tb_vce2_agu_mc.sv
// Scoreboard bench for vce2_agu_mc: a reference model queues expected addresses
// per channel stream; DUT outputs are popped and compared as requests are accepted.
module tb_vce2_agu_mc;

  localparam int AW = 32, NO = 3, SW = 12, MV = 64, VW = 7, OW = 2, CW = 30;

  logic           clk_i = 1'b0, rst_ni = 1'b0;
  logic           start_i = 1'b0, abort_i = 1'b0, base_valid_i = 1'b0, req_i = 1'b0;
  logic [VW-1:0]  vl_i = '0;
  logic [OW-1:0]  op_sel_i = '0;
  logic [CW-1:0]  base_addr_i;
  logic [SW-1:0]  stride_i;
  logic           base_ready_o, addr_valid_o, last_o, busy_o, done_o;
  logic [OW-1:0]  rf_port_sel_o;
  logic [AW-1:0]  addr_o;
  logic [NO-1:0]  ovf_o;

  // Register-file model: read mux steered by the AGU's port select.
  logic [CW-1:0]  rf_base   [4];
  logic [SW-1:0]  rf_stride [4];
  assign base_addr_i = rf_base[rf_port_sel_o];
  assign stride_i    = rf_stride[rf_port_sel_o];

  vce2_agu_mc dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .vl_i(vl_i), .abort_i(abort_i),
    .base_valid_i(base_valid_i), .base_ready_o(base_ready_o), .base_addr_i(base_addr_i),
    .stride_i(stride_i), .rf_port_sel_o(rf_port_sel_o), .op_sel_i(op_sel_i), .req_i(req_i),
    .addr_o(addr_o), .addr_valid_o(addr_valid_o), .last_o(last_o), .busy_o(busy_o),
    .done_o(done_o), .ovf_o(ovf_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          last;
  } exp_t;

  exp_t          exp_q [$];
  logic [CW-1:0] m_cnt [NO];
  logic [SW-1:0] m_str [NO];
  int            m_rem [NO];
  logic [NO-1:0] m_ovf = '0;
  int            n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [CW-1:0] sext(input logic [SW-1:0] s);
    return {{(CW-SW){s[SW-1]}}, s};
  endfunction

  function automatic logic [NO-1:0] exp_ovf();
`ifdef VCE2_AGU_OVF_EN
    return m_ovf;
`else
    return '0;
`endif
  endfunction

  task automatic load_op(input int vl, input int bp_at, input int bp_len);
    start_i = 1'b1;
    vl_i    = VW'(vl);
    tick();
    start_i = 1'b0;
    m_ovf   = '0;
    for (int i = 0; i < NO; i++) begin
      m_cnt[i] = rf_base[i];
      m_str[i] = rf_stride[i];
      m_rem[i] = (vl > MV) ? MV : vl;
    end
    for (int k = 0; k < NO; k++) begin
      if (k == bp_at) begin
        base_valid_i = 1'b0;
        for (int b = 0; b < bp_len; b++) begin
          #1;
          check("bp_sel", rf_port_sel_o, k);
          check("bp_ready", base_ready_o, 1);
          tick();
        end
      end
      base_valid_i = 1'b1;
      #1;
      check("load_sel", rf_port_sel_o, k);
      check("load_ready", base_ready_o, 1);
      tick();
    end
    base_valid_i = 1'b0;
    #1;
    check("run_ready", base_ready_o, 0);
    check("run_busy", busy_o, 1);
  endtask

  // Drain one channel; optionally poke an extra request once it is empty.
  task automatic stream(input int ch, input bit poke);
    exp_t          e;
    logic [CW-1:0] nxt;
    int            guard;
    for (int j = 0; j < m_rem[ch]; j++) begin
      e.addr = {m_cnt[ch], 2'b00};
      e.last = (j == m_rem[ch] - 1);
      exp_q.push_back(e);
      nxt = m_cnt[ch] + sext(m_str[ch]);
      if (!m_str[ch][SW-1] && (nxt < m_cnt[ch])) m_ovf[ch] = 1'b1;
      if (m_str[ch][SW-1] && (nxt > m_cnt[ch]))  m_ovf[ch] = 1'b1;
      m_cnt[ch] = nxt;
    end
    m_rem[ch] = 0;
    op_sel_i  = OW'(ch);
    req_i     = 1'b1;
    guard     = 0;
    #1;
    while (exp_q.size() > 0 && guard < 200) begin
      if (!addr_valid_o) begin
        check("stream_valid", addr_valid_o, 1);
        exp_q.delete();
        break;
      end
      e = exp_q.pop_front();
      check("addr", addr_o, e.addr);
      check("last", last_o, e.last);
      tick();
      guard++;
    end
    if (exp_q.size() > 0) begin
      check("stream_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    req_i = 1'b0;
    #1;
    check("drained_valid", addr_valid_o, 0);
    if (poke) begin
      req_i = 1'b1;
      tick();
      req_i = 1'b0;
      #1;
      check("ignored_req_addr", addr_o, {m_cnt[ch], 2'b00});
      check("ignored_req_valid", addr_valid_o, 0);
    end
  endtask

  task automatic expect_done();
    #1;
    check("pre_done", done_o, 0);
    check("pre_done_busy", busy_o, 1);
    tick();
    check("done_pulse", done_o, 1);
    check("done_busy", busy_o, 0);
    tick();
    check("done_clear", done_o, 0);
  endtask

  task automatic set_rf(input logic [CW-1:0] b0, input logic [SW-1:0] s0,
                        input logic [CW-1:0] b1, input logic [SW-1:0] s1,
                        input logic [CW-1:0] b2, input logic [SW-1:0] s2);
    rf_base[0] = b0; rf_stride[0] = s0;
    rf_base[1] = b1; rf_stride[1] = s1;
    rf_base[2] = b2; rf_stride[2] = s2;
    rf_base[3] = '0; rf_stride[3] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    set_rf('0, '0, '0, '0, '0, '0);
    #2;
    check("rst_addr", addr_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_ready", base_ready_o, 0);
    check("rst_sel", rf_port_sel_o, 0);
    check("rst_valid", addr_valid_o, 0);
    check("rst_last", last_o, 0);
    check("rst_ovf", ovf_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Load sequence and unit-stride streams
    set_rf(30'h100, 12'd1, 30'h200, 12'd1, 30'h300, 12'd1);
    load_op(4, -1, 0);
    op_sel_i = 2'd3;
    #1;
    check("badsel_addr", addr_o, 0);
    check("badsel_valid", addr_valid_o, 0);
    stream(0, 1'b1);
    stream(2, 1'b0);
    stream(1, 1'b0);
    check("ovf_none", ovf_o, exp_ovf());
    expect_done();

    // Back-pressure in LOAD, negative and zero strides
    set_rf(30'h55, 12'd0, 30'h10, 12'hFFE, 30'h1000, 12'd3);
    load_op(3, 1, 5);
    stream(1, 1'b0);
    stream(0, 1'b0);
    stream(2, 1'b0);
    expect_done();

    // Zero-length start completes without loading
    start_i = 1'b1;
    vl_i    = '0;
    tick();
    start_i = 1'b0;
    check("vl0_done", done_o, 1);
    check("vl0_busy", busy_o, 0);
    check("vl0_ready", base_ready_o, 0);
    tick();
    check("vl0_done_clear", done_o, 0);

    // Saturated element count, then abort mid-RUN
    set_rf(30'h2000, 12'd2, 30'h3000, 12'd1, 30'h4000, 12'd1);
    load_op(127, -1, 0);
    stream(0, 1'b0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_done", done_o, 0);
    check("abort_valid", addr_valid_o, 0);
    tick();
    check("abort_done_later", done_o, 0);

    // Asynchronous reset mid-LOAD
    start_i = 1'b1;
    vl_i    = 7'd2;
    tick();
    start_i      = 1'b0;
    base_valid_i = 1'b1;
    tick();
    base_valid_i = 1'b0;
    #1;
    check("midload_sel", rf_port_sel_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_ready", base_ready_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_sel", rf_port_sel_o, 0);
    check("arst_done", done_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Wrap past the top and bottom of the word address space
    set_rf(30'h3FFFFFFF, 12'd1, 30'h20, 12'hFFF, 30'h0, 12'hFFF);
    load_op(2, -1, 0);
    stream(0, 1'b0);
    check("ovf_top", ovf_o, exp_ovf());
    stream(1, 1'b0);
    stream(2, 1'b0);
    check("ovf_bottom", ovf_o, exp_ovf());
    expect_done();
    check("ovf_sticky", ovf_o, exp_ovf());
    start_i = 1'b1;
    vl_i    = '0;
    tick();
    start_i = 1'b0;
    m_ovf   = '0;
    check("ovf_cleared", ovf_o, exp_ovf());
    check("ovf_clr_done", done_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vce2_agu_mc.md
Name: vce2_agu_mc

Overview:
- Multi-channel, strided address generation unit for the vector coprocessor memory path.
- Holds one word-address counter per vector operand: NumOps channels, typically rs1, rs2 and rd.
- Loads the base addresses in sequence from the register-file read path through a valid/ready handshake.
- Then streams byte addresses per channel with a programmable signed stride and an element count.
- Signals last element, completion and optional overflow to the vector register file and sequencer.

Parameters:
AddrWidth, 32, byte address width; counters hold AddrWidth-2 bits (word address)
NumOps, 3, number of operand channels (>=1)
StrideWidth, 12, width of signed word stride
MaxVl, 64, maximum elements per operand; VlW = $clog2(MaxVl+1), OpW = max(1,$clog2(NumOps))

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
start_i  in  1  start new vector op (sampled in IDLE only)
vl_i  in  VlW  element count per operand, sampled with start_i
abort_i  in  1  return to IDLE
base_valid_i  in  1  base_addr_i/stride_i valid
base_ready_o  out  1  AGU accepts base for channel rf_port_sel_o
base_addr_i  in  AddrWidth-2  word base address
stride_i  in  StrideWidth  signed word stride for that channel
rf_port_sel_o  out  OpW  channel whose base is requested (drives RF read mux)
op_sel_i  in  OpW  channel addressed during RUN
req_i  in  1  consume current address of op_sel_i
addr_o  out  AddrWidth  byte address {cnt[op_sel_i],2'b00}
addr_valid_o  out  1  op_sel_i channel has remaining elements
last_o  out  1  current element is last of op_sel_i channel
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse: all channels exhausted
ovf_o  out  NumOps  sticky per-channel wrap flag (optional feature)

Behaviour:
- Reset values: state IDLE; all counters, strides, remaining counts and load index 0; all outputs 0.
- States are IDLE, LOAD and RUN; state register is flopped; all outputs are combinational from registered state.
- IDLE:
  - start_i=1 and vl_i!=0: latch vl; load index k=0; go to LOAD.
  - start_i=1 and vl_i==0: stay IDLE; done_o=1 in the following cycle.
  - vl_i>MaxVl saturates to MaxVl.
- LOAD:
  - base_ready_o=1 and rf_port_sel_o=k.
  - On base_valid_i: cnt[k]<=base_addr_i, str[k]<=stride_i, rem[k]<=vl, k<=k+1.
  - Handshake with k=NumOps-1: go to RUN. Exactly NumOps handshakes; base_valid_i with no ready is held off without loss.
- RUN:
  - addr_valid_o = rem[op_sel_i]!=0.
  - last_o = rem[op_sel_i]==1.
  - base_ready_o=0.
  - req_i & addr_valid_o: cnt[op_sel_i] += sign-extended str, modulo 2^(AddrWidth-2); rem[op_sel_i] -= 1. Takes effect next cycle; zero-latency address for the current element.
  - req_i with addr_valid_o=0: ignored, no counter change.
  - All rem==0 (checked on registered values): done_o=1 for one cycle; next state IDLE.
  - Only one channel advances per cycle.
- A stride of 0 repeats the base address vl times; a negative stride decrements.
- abort_i has priority in any state: next state IDLE, no done_o; counters retain value.
- start_i is ignored while busy_o=1.
- Reset asserted mid-operation: immediate return to reset values, no done_o.
- addr_o is 0 when state != RUN or op_sel_i >= NumOps.

Optional Feature:
- Macro: VCE2_AGU_OVF_EN.
- Defined:
  - ovf_o[i] is set when an increment of channel i wraps past the top or bottom of the word address space (carry/borrow out of AddrWidth-2 bits).
  - The flag is sticky and cleared on an accepted start_i.
  - Counter still wraps modulo.
- Undefined: ovf_o is tied to 0 and no carry logic is synthesised.

Test Plan:
- Load and sequence:
  - Stimulus: start vl=4; bases 0x100, 0x200, 0x300 with stride 1, base_valid_i held high.
  - Response: rf_port_sel_o = 0,1,2 in three consecutive cycles; RUN entered on the 4th cycle.
- Channel 0 stream:
  - Stimulus: op_sel_i=0, req_i high.
  - Response: addr_o = 0x400, 0x404, 0x408, 0x40C; last_o on the 4th; then addr_valid_o=0.
- Negative stride and done:
  - Stimulus: stride -2, base 0x10, vl=3 on channel 1.
  - Response: addr_o = 0x40, 0x38, 0x30; done_o pulses once after all channels drain; busy_o falls the same cycle.
- Back-pressure:
  - Stimulus: base_valid_i low for 5 cycles in LOAD.
  - Response: k is held, base_ready_o stays 1, no state change. Also, vl_i=0 start gives a done_o pulse one cycle later without entering LOAD.
- Abort and reset:
  - Stimulus: abort_i mid-RUN.
  - Response: IDLE next cycle, no done_o. rst_ni low mid-LOAD returns all outputs to 0 asynchronously.
- Wrap (with VCE2_AGU_OVF_EN):
  - Stimulus: base 0x3FFFFFFF, stride 1, vl=2, AddrWidth=32.
  - Response: addr_o = 0xFFFFFFFC then 0x00000000; ovf_o[ch]=1 until the next start_i.
